// File: rtl/tiny_out_uart.sv
// tiny_out_uart: spots each executed OUT, queues the new output-buffer word in a
// 4-deep FIFO and sends it as two 8N1 frames (high byte first) on tx.
// Ports: clk, reset (sync, active-high), cs/irout/out from the CPU;
//        tx (serial, idles high), busy, count (FIFO occupancy), overflow (sticky).
module tiny_out_uart #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [2:0] EXECA_CODE   = 3'd2,
  parameter logic [3:0] OUT_OPCODE   = 4'b0111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cs,
  input  logic [15:0] irout,
  input  logic [15:0] out,
  output logic        tx,
  output logic        busy,
  output logic [2:0]  count,
  output logic        overflow
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic          pend;
  logic [15:0]   mem [4];
  logic [1:0]    wp;
  logic [1:0]    rp;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic [15:0]   word;
  logic          hilo;
  logic [2:0]    idx;
  logic [BW-1:0] baud;
  logic [7:0]    cur_byte;
  logic          last;
  logic          unused_irout;

  assign unused_irout = ^irout[11:0];

  // pend marks the cycle in which out already holds the new value
  assign push     = pend;
  assign pop      = (state == IDLE) && (count != 3'd0);
  // a full FIFO still accepts a word if the head leaves in the same cycle
  assign push_ok  = push && ((count != 3'd4) || pop);
  assign cur_byte = hilo ? word[15:8] : word[7:0];
  assign last     = (baud == BAUD_MAX);
  assign busy     = (state != IDLE) || (count != 3'd0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= 1'b0;
      wp       <= 2'd0;
      rp       <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      pend <= (cs == EXECA_CODE) && (irout[15:12] == OUT_OPCODE);
      if (push_ok) begin
        wp <= wp + 2'd1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rp <= rp + 2'd1;
      end
      if (push_ok && !pop) begin
        count <= count + 3'd1;
      end else if (!push_ok && pop) begin
        count <= count - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      word  <= 16'h0000;
      hilo  <= 1'b0;
      idx   <= 3'd0;
      baud  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            word  <= mem[rp];
            hilo  <= 1'b1;
            baud  <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (last) begin
            baud  <= '0;
            idx   <= 3'd0;
            tx    <= cur_byte[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (last) begin
            baud <= '0;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= cur_byte[idx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (last) begin
            baud <= '0;
            if (hilo) begin
              // low byte follows with no idle gap
              hilo  <= 1'b0;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_out_uart.sv
// tb_tiny_out_uart: random and directed OUT traffic, expected words queued at
// issue time and compared against words decoded from tx by a UART receiver.
module tb_tiny_out_uart;

  localparam int         C  = 16;
  localparam logic [2:0] EX = 3'd2;
  localparam logic [3:0] OP = 4'h7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cs;
  logic [15:0] irout;
  logic [15:0] out;
  logic        tx;
  logic        busy;
  logic [2:0]  count;
  logic        overflow;

  always #5 clk = ~clk;

  tiny_out_uart #(
    .CLKS_PER_BIT(C),
    .EXECA_CODE  (EX),
    .OUT_OPCODE  (OP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .irout   (irout),
    .out     (out),
    .tx      (tx),
    .busy    (busy),
    .count   (count),
    .overflow(overflow)
  );

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // UART receiver: samples mid-bit on negedges, pairs bytes into words
  int         rx_st = 0;
  int         rx_cnt = 0;
  int         rx_half = 0;
  int         maxc = 0;
  logic [9:0] rx_bits;
  logic [7:0] rx_hi;

  always @(negedge clk) begin
    if (int'(count) > maxc) maxc = int'(count);
    if (reset) begin
      rx_st   = 0;
      rx_half = 0;
    end else if (rx_st == 0) begin
      if (tx === 1'b0) begin
        rx_st  = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2) begin
        rx_bits[rx_cnt / C] = tx;
        if (rx_cnt / C == 9) begin
          rx_st = 0;
          check("frame", {30'd0, rx_bits[9], rx_bits[0]}, 32'd2);
          if (rx_half == 0) begin
            rx_hi   = rx_bits[8:1];
            rx_half = 1;
          end else begin
            rx_half = 0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_word: got %0h want none",
                       {rx_hi, rx_bits[8:1]});
            end else begin
              check("word", {16'd0, rx_hi, rx_bits[8:1]},
                    {16'd0, exp_q.pop_front()});
            end
          end
        end
      end
    end
  end

  task automatic idle_cyc();
    cs    = 3'($urandom_range(0, 7));
    irout = 16'($urandom);
    if (cs == EX && irout[15:12] == OP) irout[15:12] = 4'h0;
    @(negedge clk);
  endtask

  // EXECA of an OUT for one cycle, then the CPU's new out value
  task automatic do_out(input logic [15:0] v, input int gap, input bit exp);
    cs    = EX;
    irout = {OP, 12'($urandom)};
    if (exp) exp_q.push_back(v);
    @(negedge clk);
    cs = 3'($urandom_range(0, 7));
    if (cs == EX) cs = 3'd0;
    irout = 16'($urandom);
    out   = v;
    @(negedge clk);
    repeat (gap) idle_cyc();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || rx_st != 0) && n < 8 * 21 * C) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 8 * 21 * C) begin
      fails++;
      $display("FAIL %s_timeout: got busy=%0d queued=%0d want idle",
               name, busy, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic logic wave_bit(input logic [15:0] w, input int k);
    int         b;
    int         bb;
    logic [7:0] by;
    b  = k / C;
    bb = b % 10;
    by = (b < 10) ? w[15:8] : w[7:0];
    if (bb == 0) return 1'b0;
    if (bb == 9) return 1'b1;
    return by[bb-1];
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ops[8];
    int          bad;
    int          n;
    logic [15:0] w;
    ops   = '{0, 1, 2, 3, 4, 5, 6, 8};
    cs    = EX;
    irout = 16'h7000;
    out   = 16'h0000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    cs    = 3'd0;
    irout = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_hold_count", {29'd0, count}, 32'd0);

    foreach (ops[i]) begin
      cs    = EX;
      irout = {4'(ops[i]), 12'($urandom)};
      @(negedge clk);
      cs = 3'd0;
      @(negedge clk);
      @(negedge clk);
      check("nonout_count", {29'd0, count}, 32'd0);
      check("nonout_tx", {31'd0, tx}, 32'd1);
    end

    do_out(16'hA53C, 0, 1);
    check("single_count", {29'd0, count}, 32'd1);
    check("single_pre_tx", {31'd0, tx}, 32'd1);
    bad = 0;
    for (int k = 0; k < 20 * C; k++) begin
      @(negedge clk);
      if (k == 0) check("single_fall", {31'd0, tx}, 32'd0);
      if (tx !== wave_bit(16'hA53C, k)) bad++;
    end
    check("single_wave", 32'(bad), 32'd0);
    check("single_busy_end", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_busy_off", {31'd0, busy}, 32'd0);
    wait_idle("single");

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        do_out(16'($urandom), (i == n - 1) ? 0 : $urandom_range(1, 4), 1);
      end
      wait_idle("burst");
      check("burst_ovf", {31'd0, overflow}, 32'd0);
    end

    for (int i = 0; i < 5; i++) do_out(16'($urandom), 1, 1);
    check("full_count", {29'd0, count}, 32'd4);
    repeat (2 + 20 * C - 15) @(negedge clk);
    w = 16'($urandom);
    do_out(w, 0, 1);
    check("pushpop_count", {29'd0, count}, 32'd4);
    check("pushpop_ovf", {31'd0, overflow}, 32'd0);
    wait_idle("pushpop");

    maxc = 0;
    for (int i = 1; i <= 6; i++) do_out(16'(i), (i == 6) ? 0 : 1, i <= 5);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {29'd0, count}, 32'd4);
    wait_idle("ovf");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_peak", 32'(maxc), 32'd4);

    do_out(16'h1234, 1, 1);
    do_out(16'h5678, 1, 1);
    do_out(16'h9ABC, 0, 1);
    check("mid_count", {29'd0, count}, 32'd2);
    repeat (4 * C + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("mid_tx", {31'd0, tx}, 32'd1);
    check("mid_count0", {29'd0, count}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cs    = 3'd0;
    bad   = 0;
    for (int k = 0; k < 25 * C; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("mid_quiet", 32'(bad), 32'd0);
    do_out(16'h00FF, 0, 1);
    wait_idle("after_reset");
    check("final_count", {29'd0, count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
